// File: rtl/prog_loader.sv
// Boot-time program loader: checks the ASRM header, streams the image into program memory and holds the CPU until done.
// Optional zero-fill of memory above the image is enabled by defining PROG_LOADER_CLEAR_EN.
module prog_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_write,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
`ifdef PROG_LOADER_CLEAR_EN
    S_CLEAR  = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_data;
  logic                  r_mem_write;
  logic                  r_done;
  logic [7:0]            w_magic;
  logic                  w_accept;
  logic                  w_match;
  logic                  w_at_top;

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_magic = 8'h41;
      2'd1:    w_magic = 8'h53;
      2'd2:    w_magic = 8'h52;
      default: w_magic = 8'h4D;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_match  = (in_data == w_magic);
  assign w_at_top = (r_addr == ADDR_TOP);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_HEADER;
      end
      S_HEADER: begin
        if (w_accept) begin
          if (!w_match || in_last)   w_state_next = S_ERROR;
          else if (r_addr[1:0] == 2'd3) w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (in_last) begin
`ifdef PROG_LOADER_CLEAR_EN
            w_state_next = w_at_top ? S_DONE : S_CLEAR;
`else
            w_state_next = S_DONE;
`endif
          end else if (w_at_top) begin
            w_state_next = S_ERROR;
          end
        end
      end
`ifdef PROG_LOADER_CLEAR_EN
      S_CLEAR: begin
        if (w_at_top) w_state_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (start) w_state_next = S_HEADER;
      end
      S_ERROR: w_state_next = S_ERROR;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    error    = 1'b0;
    done     = r_done;
    cpu_hold = ~r_done;
    case (r_state)
      S_HEADER, S_LOAD: in_ready = 1'b1;
      S_ERROR:          error    = 1'b1;
      default: ;
    endcase
  end

  // done lags DONE entry by one cycle so it follows the final registered write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= 8'h00;
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_done      <= (r_state == S_DONE) && (w_state_next == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) r_addr <= '0;
        end
        S_HEADER: begin
          if (w_accept && w_match) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_data  <= in_data;
            r_addr      <= r_addr + ADDR_ONE;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_data  <= in_data;
            if (!w_at_top) r_addr <= r_addr + ADDR_ONE;
          end
        end
`ifdef PROG_LOADER_CLEAR_EN
        S_CLEAR: begin
          r_mem_write <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_data  <= 8'h00;
          if (!w_at_top) r_addr <= r_addr + ADDR_ONE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_write = r_mem_write;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle table for the clean image plus hand sequences for error, stall and reset cases.
module tb_prog_loader;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_write;
  logic          cpu_hold;
  logic          done;
  logic          error;

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] wr_q[$];
  always @(negedge clk) begin
    if (mem_write === 1'b1) wr_q.push_back({mem_addr, mem_data});
  end

  typedef struct {
    logic       start, valid, last;
    logic [7:0] data;
    logic       ready, wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       dn, hold, err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output logic ok);
    logic rdy;
    in_valid = 1'b1; in_data = d; in_last = l; ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      rdy = in_ready;
      tick();
      if (rdy === 1'b1) ok = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < max_cyc && !ok; t++) begin
      if (done === 1'b1) ok = 1'b1;
      else tick();
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic send_image(input string name, input logic [7:0] img[$], input bit gaps);
    logic ok;
    for (int i = 0; i < img.size(); i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0; in_data = 8'($urandom); tick();
        end
      end
      send_byte(img[i], i == img.size() - 1, ok);
      if (!ok) chk({name, "_accept"}, {31'd0, ok}, 32'd1);
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] img[$]);
    chk({name, "_nwr"}, wr_q.size(), img.size());
    for (int i = 0; i < img.size() && i < wr_q.size(); i++)
      chk({name, "_wr"}, {17'd0, wr_q[i]}, {17'd0, 7'(i), img[i]});
  endtask

  initial begin
    logic [7:0] img[$];
    logic ok;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img[$];
    logic ok;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 7'h00, 8'h41, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h53, 1'b1, 1'b1, 7'h01, 8'h53, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h52, 1'b1, 1'b1, 7'h02, 8'h52, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h4D, 1'b1, 1'b1, 7'h03, 8'h4D, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h14, 1'b1, 1'b1, 7'h04, 8'h14, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 7'h05, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1, 7'h06, 8'h0E, 1'b0, 1'b1, 1'b0};

    // reset state
    do_reset();
    chk("reset_state", {12'd0, in_ready, mem_write, mem_addr, mem_data, cpu_hold, done, error},
        {12'd0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    $display("[TB] reset state checked");

    // good image, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start; in_valid = vecs[i].valid; in_last = vecs[i].last; in_data = vecs[i].data;
      tick();
      chk($sformatf("good_vec%0d", i),
          {12'd0, in_ready, mem_write, mem_addr, mem_data, done, cpu_hold, error},
          {12'd0, vecs[i].ready, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dn, vecs[i].hold, vecs[i].err});
      $display("[TB] good vec %0d data=%h wr=%b addr=%h", i, vecs[i].data, mem_write, mem_addr);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
`ifdef PROG_LOADER_CLEAR_EN
    for (int k = 7; k < 128; k++) begin
      tick();
      chk("good_clear_wr", {20'd0, mem_write, mem_addr, mem_data, done},
          {20'd0, 1'b1, 7'(k), 8'h00, 1'b0});
    end
`endif
    tick();
    chk("good_done", {29'd0, mem_write, done, cpu_hold}, {29'd0, 1'b0, 1'b1, 1'b0});
    $display("[TB] good image done=%b cpu_hold=%b", done, cpu_hold);

    // bad magic
    do_reset(); wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53, 8'h00};
    send_image("badmagic", img, 1'b0);
    repeat (3) tick();
    img = '{8'h41, 8'h53};
    check_log("badmagic", img);
    chk("badmagic_flags", {29'd0, error, cpu_hold, in_ready}, {29'd0, 1'b1, 1'b1, 1'b0});
    pulse_start(); repeat (3) tick();
    chk("badmagic_start_ignored", {28'd0, error, cpu_hold, in_ready, done}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("badmagic_nwr_after_start", wr_q.size(), 32'd2);
    $display("[TB] bad magic error=%b writes=%0d", error, wr_q.size());

    // short image
    do_reset(); wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53};
    send_image("short", img, 1'b0);
    repeat (2) tick();
    check_log("short", img);
    chk("short_error", {30'd0, error, in_ready}, {30'd0, 1'b1, 1'b0});
    $display("[TB] short image error=%b", error);

    // overflow: 128 bytes accepted, 129th refused
    do_reset(); wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    for (int i = 4; i < 128; i++) img.push_back(8'(i) ^ 8'hA5);
    for (int i = 0; i < 128; i++) begin
      send_byte(img[i], 1'b0, ok);
      if (!ok) chk("overflow_accept", {31'd0, ok}, 32'd1);
    end
    send_byte(8'hEE, 1'b0, ok);
    chk("overflow_129th_refused", {31'd0, ok}, 32'd0);
    check_log("overflow", img);
    chk("overflow_flags", {29'd0, error, cpu_hold, done}, {29'd0, 1'b1, 1'b1, 1'b0});
    $display("[TB] overflow writes=%0d error=%b", wr_q.size(), error);

    // backpressure and gaps on a 16-byte image
    do_reset(); wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    for (int i = 4; i < 16; i++) img.push_back(8'(i * 7 + 3));
    send_image("gaps", img, 1'b1);
    wait_done("gaps_done", 300);
`ifdef PROG_LOADER_CLEAR_EN
    for (int i = 16; i < 128; i++) img.push_back(8'h00);
`endif
    check_log("gaps", img);
    chk("gaps_hold", {31'd0, cpu_hold}, 32'd0);
    $display("[TB] gaps image writes=%0d done=%b", wr_q.size(), done);
    pulse_start();
    chk("restart_from_done", {29'd0, done, cpu_hold, in_ready}, {29'd0, 1'b0, 1'b1, 1'b1});
    $display("[TB] restart from done in_ready=%b", in_ready);

    // reset at byte 10 of 20, then a fresh 8-byte load
    do_reset(); wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    for (int i = 4; i < 9; i++) img.push_back(8'(8'h60 + i));
    for (int i = 0; i < 9; i++) begin
      send_byte(img[i], 1'b0, ok);
      if (!ok) chk("midreset_accept", {31'd0, ok}, 32'd1);
    end
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    chk("midreset_no_write", {31'd0, mem_write}, 32'd0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    repeat (4) tick();
    check_log("midreset", img);
    chk("midreset_idle", {30'd0, in_ready, cpu_hold}, {30'd0, 1'b0, 1'b1});
    wr_q.delete(); pulse_start();
    img = '{8'h41, 8'h53, 8'h52, 8'h4D, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_image("reload", img, 1'b0);
    wait_done("reload_done", 300);
`ifdef PROG_LOADER_CLEAR_EN
    for (int i = 8; i < 128; i++) img.push_back(8'h00);
`endif
    check_log("reload", img);
    $display("[TB] reload writes=%0d done=%b", wr_q.size(), done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the Reflet CPU's 128-byte program memory at boot. It accepts an image over a valid/ready byte stream, checks the 4-byte `ASRM` magic header (0x41 0x53 0x52 0x4D), and writes every accepted byte to consecutive memory addresses starting at 0. It holds the CPU in reset until the image is complete. It is the write-side counterpart of the program ROMs the CPU fetches from.

## Interface
- `ADDR_WIDTH`, default 7: program memory address width; depth is 2**ADDR_WIDTH bytes.
- `clk  in  1`: single clock; all logic on rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `in_data  in  8`: image byte.
- `in_valid  in  1`: `in_data` is valid.
- `in_last  in  1`: qualifies the final image byte.
- `in_ready  out  1`: loader can accept a byte this cycle.
- `mem_addr  out  ADDR_WIDTH`: write address.
- `mem_data  out  8`: write data.
- `mem_write  out  1`: one-cycle write strobe.
- `cpu_hold  out  1`: drives the CPU reset; high means the CPU is held.
- `done  out  1`: image loaded successfully; level.
- `error  out  1`: bad header, short image or overflow; sticky level.

## Operation
- States: IDLE, HEADER, LOAD, CLEAR, DONE, ERROR.
- IDLE: `in_ready`=0. `start` moves to HEADER; the address counter is cleared to 0.
- HEADER: `in_ready`=1. Each accepted byte (`in_valid && in_ready`) is compared with the magic byte at the current index 0..3.
  - Match: the byte is written to memory and the counter increments.
  - Mismatch: nothing is written; go to ERROR.
  - `in_last` on any header byte: go to ERROR after the write, since the image is shorter than 4 bytes.
  - After the 4th matching byte: go to LOAD.
- LOAD: `in_ready`=1. Each accepted byte is written at the counter, then the counter increments.
  - `in_last`: go to CLEAR (or DONE, see Configuration).
  - Byte accepted at address 2**ADDR_WIDTH-1 without `in_last`: the byte is written, then go to ERROR (overflow).
- CLEAR: `in_ready`=0. Writes 0x00 to each address from last+1 up to 2**ADDR_WIDTH-1, one per cycle, then goes to DONE. CLEAR is skipped if the last byte landed at the top address.
- DONE: `done`=1, `cpu_hold`=0. A `start` pulse returns to HEADER with `done`=0 and `cpu_hold`=1.
- ERROR: `error`=1, `cpu_hold`=1, `in_ready`=0. Left only by `reset`; `start` is ignored.
- `start` in HEADER, LOAD or CLEAR: ignored.
- `cpu_hold`=1 in every state except DONE.
- Address arithmetic is unsigned ADDR_WIDTH bits. The counter never wraps; wrap would occur only on overflow, which is an error.

## Timing
- Reset values: `in_ready`=0, `mem_write`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=1, `done`=0, `error`=0. State is IDLE.
- Write latency: a byte accepted in cycle N gives `mem_write`=1 with that address and data in cycle N+1. All memory outputs are registered.
- Sustained throughput: 1 byte per cycle while `in_valid` is held high.
- `in_ready` is a registered state decode. It drops in the cycle after `in_last` is accepted.
- CLEAR issues one write per cycle.
- `done` rises in the cycle after the final write strobe. `cpu_hold` falls in that same cycle.
- Reset mid-load: state returns to IDLE on the next edge and `mem_write` is 0 from that cycle on. Writes already issued stay in memory.

## Configuration
- `PROG_LOADER_CLEAR_EN` defined: the CLEAR state is present, so memory above the image reads 0x00, matching the ROM default.
- Not defined: CLEAR is not compiled. LOAD goes straight to DONE after the last write, and memory above the image keeps its previous contents.

## Test plan
- Good image: stream 41 53 52 4D 14 3C 0E with `in_last` on 0E, no stalls.
  - Writes to addresses 0x00–0x06 with exactly these bytes.
  - `done`=1 and `cpu_hold`=0 one cycle after the write to 0x06.
  - With `PROG_LOADER_CLEAR_EN`: 121 zero writes at 0x07–0x7F before `done`.
- Bad magic: stream 41 53 00.
  - Writes only at 0x00 and 0x01.
  - `error`=1, `cpu_hold`=1, `in_ready`=0 afterwards.
  - A later `start` has no effect.
- Short image: stream 41 53 with `in_last` on 53 → `error`=1 after the write to 0x01.
- Overflow: a valid header followed by 125 more bytes (129 total), no `in_last`.
  - Write at 0x7F happens, then `error`=1.
  - The 129th byte is never accepted (`in_ready`=0).
- Backpressure and gaps: toggle `in_valid` randomly during a 16-byte image → identical write sequence with no duplicates and no skipped addresses.
- Reset at byte 10 of 20, then restart with `start` and a new 8-byte image.
  - No writes after reset.
  - Second load writes from 0x00 and reaches DONE.
